// File: rtl/core_pkg.sv
// Shared definitions for the core front end: widths, reset PC, fetch FSM
// states and the word-alignment helper.
package core_pkg;

  localparam int unsigned     XLEN     = 32;
  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;

  // Widest address the alignment helper handles; callers cast in and out.
  localparam int unsigned     ALIGN_W  = 64;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH
  } fetch_state_t;

  function automatic logic [ALIGN_W-1:0] align(input logic [ALIGN_W-1:0] addr);
    return {addr[ALIGN_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of {pc, instr} entries with clear; head is read
// combinationally from storage so occupancy changes are visible next cycle.
module fetch_queue #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  input  logic                     clear,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign rdata   = mem[rd_ptr[AW-1:0]];

  // A pop frees the head slot in the same cycle, so push is allowed when full.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: credit-limited sequential fetch over a
// ready/valid memory port, in-order response queue, redirect with flush.
module fetch_unit #(
  parameter int unsigned     XLEN     = core_pkg::XLEN,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(core_pkg::RESET_PC)
) (
  input  logic            clk,
  input  logic            rst,
  output logic            instr_read,
  output logic [XLEN-1:0] instr_addr,
  input  logic            instr_ready,
  input  logic            instr_rvalid,
  input  logic [XLEN-1:0] instr_out,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            fetch_valid,
  output logic [XLEN-1:0] fetch_pc,
  output logic [XLEN-1:0] fetch_instr,
  input  logic            fetch_ready
);

  import core_pkg::*;

  localparam int unsigned     AW   = $clog2(DEPTH);
  localparam int unsigned     CW   = AW + 1;
  localparam logic [XLEN-1:0] STEP = XLEN'(4);

  fetch_state_t      state_q, state_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]   rsp_pc_q, rsp_pc_d;
  logic [XLEN-1:0]   redirect_al;
  logic [CW-1:0]     outst_q, outst_d;
  logic [CW-1:0]     discard_q, discard_d;
  logic [CW-1:0]     q_count;
  logic              accept;
  logic              q_push;
  logic              q_pop;
  logic              q_full;
  logic              q_empty;
  logic [2*XLEN-1:0] q_rdata;

  assign redirect_al = XLEN'(align(ALIGN_W'(redirect_pc)));

  // Queued entries plus in-flight requests never exceed DEPTH, so every
  // response has a guaranteed slot.
  assign instr_read = (state_q == RUN) &&
                      (((CW+1)'(q_count) + (CW+1)'(outst_q)) < (CW+1)'(DEPTH));
  assign instr_addr = addr_q;
  assign accept     = instr_read && instr_ready;
  assign outst_d    = outst_q + CW'(accept) - CW'(instr_rvalid);

  assign q_pop      = !q_empty && fetch_ready;
  assign q_push     = (state_q == RUN) && instr_rvalid && !redirect_valid &&
                      (!q_full || q_pop);

  fetch_queue #(
    .WIDTH (2*XLEN),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (q_push),
    .wdata ({rsp_pc_q, instr_out}),
    .pop   (q_pop),
    .clear (redirect_valid),
    .rdata (q_rdata),
    .full  (q_full),
    .empty (q_empty),
    .count (q_count)
  );

  assign fetch_valid = !q_empty;
  assign fetch_pc    = q_empty ? '0 : q_rdata[2*XLEN-1:XLEN];
  assign fetch_instr = q_empty ? '0 : q_rdata[XLEN-1:0];

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rsp_pc_d  = rsp_pc_q;
    discard_d = discard_q;

    if (accept) addr_d   = addr_q + STEP;
    if (q_push) rsp_pc_d = rsp_pc_q + STEP;

    unique case (state_q)
      IDLE: state_d = RUN;
      RUN: begin
        // Everything still in flight, including a same-cycle accept, belongs
        // to the old path; a same-cycle response is already accounted for.
        if (redirect_valid) begin
          discard_d = outst_d;
          if (outst_d != '0) state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (instr_rvalid) discard_d = discard_q - CW'(1);
        if (discard_d == '0) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase

    if (redirect_valid) begin
      addr_d   = redirect_al;
      rsp_pc_d = redirect_al;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      addr_q    <= RESET_PC;
      rsp_pc_q  <= RESET_PC;
      outst_q   <= '0;
      discard_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rsp_pc_q  <= rsp_pc_d;
      outst_q   <= outst_d;
      discard_q <= discard_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: in-order memory model with configurable
// latency, expected-PC scoreboard consumed at every decode handshake.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] due;
  } req_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_read;
  logic [31:0] instr_addr;
  logic        instr_ready;
  logic        instr_rvalid;
  logic [31:0] instr_out;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic [31:0] fetch_instr;
  logic        fetch_ready;

  int          checks = 0;
  int          errors = 0;
  int          n_pop  = 0;
  int          n_acc  = 0;
  int unsigned cyc    = 0;
  int unsigned mem_lat = 1;

  exp_t        sb[$];
  req_t        pend[$];
  logic [31:0] acc_log[$];
  exp_t        mon_e;

  fetch_unit #(
    .XLEN     (32),
    .DEPTH    (4),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .instr_read     (instr_read),
    .instr_addr     (instr_addr),
    .instr_ready    (instr_ready),
    .instr_rvalid   (instr_rvalid),
    .instr_out      (instr_out),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch_valid    (fetch_valid),
    .fetch_pc       (fetch_pc),
    .fetch_instr    (fetch_instr),
    .fetch_ready    (fetch_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'd7) ^ 32'hC0DE_0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic expect_path(input logic [31:0] start, input int n);
    sb.delete();
    for (int i = 0; i < n; i++) begin
      logic [31:0] pc;
      pc = start + 32'(4 * i);
      sb.push_back('{pc, mem_word(pc)});
    end
  endtask

  // In-order memory: accepts sampled mid-cycle, responses after mem_lat cycles.
  initial begin : memory
    logic        acc;
    logic        fired;
    logic [31:0] acc_addr;
    instr_rvalid = 1'b0;
    instr_out    = '0;
    forever begin
      @(negedge clk);
      acc      = rst && instr_read && instr_ready;
      acc_addr = instr_addr;
      fired    = rst && instr_rvalid;
      @(posedge clk);
      #1;
      cyc++;
      if (!rst) begin
        pend.delete();
      end else begin
        if (fired && pend.size() > 0) void'(pend.pop_front());
        if (acc) begin
          pend.push_back('{acc_addr, 32'(cyc - 1 + mem_lat)});
          acc_log.push_back(acc_addr);
          n_acc++;
        end
      end
      if (rst && pend.size() > 0 && pend[0].due <= 32'(cyc)) begin
        instr_rvalid = 1'b1;
        instr_out    = mem_word(pend[0].addr);
      end else begin
        instr_rvalid = 1'b0;
        instr_out    = '0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst === 1'b1 && fetch_valid === 1'b1 && fetch_ready === 1'b1) begin
      n_pop++;
      checks++;
      assert (sb.size() > 0) else begin
        errors++;
        $error("FAIL sb_underflow observed pc=%h expected=no entry", fetch_pc);
      end
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        check("head_pc", fetch_pc, mon_e.pc);
        check("head_instr", fetch_instr, mon_e.instr);
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_read"},  {31'b0, instr_read},  32'd0);
    check({tag, "_addr"},  instr_addr,           RESET_PC);
    check({tag, "_valid"}, {31'b0, fetch_valid}, 32'd0);
    check({tag, "_pc"},    fetch_pc,             32'd0);
    check({tag, "_instr"}, fetch_instr,          32'd0);
  endtask

  task automatic do_reset(input logic fr);
    rst            = 1'b0;
    fetch_ready    = fr;
    instr_ready    = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    repeat (3) step();
    check_reset_outputs("reset");
    acc_log.delete();
    expect_path(RESET_PC, 64);
    rst = 1'b1;
  endtask

  task automatic wait_consumed(input string tag, input int n, input int budget);
    int base;
    int t;
    base = n_pop;
    t    = 0;
    while ((n_pop - base) < n && t < budget) begin
      step();
      t++;
    end
    check(tag, 32'(n_pop - base), 32'(n));
  endtask

  task automatic wait_pend(input string tag, input int n, input int budget);
    int t;
    t = 0;
    while (pend.size() != n && t < budget) begin
      step();
      t++;
    end
    check(tag, 32'(pend.size()), 32'(n));
  endtask

  task automatic redirect_now(input logic [31:0] pc, input logic [31:0] exp_start);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    @(negedge clk);
    #1;
    expect_path(exp_start, 64);
    acc_log.delete();
    @(posedge clk);
    #2;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
  endtask

  function automatic logic [31:0] acc_at(input int i);
    return (acc_log.size() > i) ? acc_log[i] : 32'hDEAD_BEEF;
  endfunction

  initial begin : main
    int          base_acc;
    int          p0;
    int          found;
    int          t;
    logic [31:0] exp_disc;

    instr_ready    = 1'b0;
    fetch_ready    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    #1;

    // Zero-wait memory, decode always ready: one instruction per cycle.
    mem_lat = 1;
    do_reset(1'b1);
    wait_consumed("t1_fill", 4, 20);
    p0 = n_pop;
    repeat (12) step();
    check("t1_rate", 32'(n_pop - p0), 32'd12);

    // Decode stalled: exactly DEPTH requests, then drain in order.
    do_reset(1'b0);
    base_acc = n_acc;
    repeat (12) step();
    check("t2_accepts", 32'(n_acc - base_acc), 32'd4);
    check("t2_read_off", {31'b0, instr_read}, 32'd0);
    check("t2_full_valid", {31'b0, fetch_valid}, 32'd1);
    check("t2_head_pc", fetch_pc, RESET_PC);
    fetch_ready = 1'b1;
    wait_consumed("t2_drain", 8, 40);
    check("t2_resume_addr", acc_at(4), 32'h0000_0010);

    // Latency 3, three outstanding, redirect to an unaligned target.
    mem_lat = 3;
    do_reset(1'b1);
    wait_pend("t3_outstanding", 3, 20);
    instr_ready = 1'b0;
    exp_disc = 32'(pend.size()) - {31'b0, instr_rvalid};
    redirect_now(32'h0000_1002, 32'h0000_1000);
    check("t3_addr", instr_addr, 32'h0000_1000);
    check("t3_discard", 32'(dut.discard_q), exp_disc);
    check("t3_read_off", {31'b0, instr_read}, 32'd0);
    instr_ready = 1'b1;
    wait_consumed("t3_new_path", 4, 40);
    check("t3_first_req", acc_at(0), 32'h0000_1000);

    // Redirect coinciding with a response and a request accept.
    mem_lat = 2;
    do_reset(1'b1);
    found = 0;
    t = 0;
    while (found == 0 && t < 20) begin
      step();
      t++;
      if (instr_rvalid === 1'b1 && instr_read === 1'b1) found = 1;
    end
    check("t4_coincide", 32'(found), 32'd1);
    exp_disc = 32'(pend.size()) + 32'd1 - 32'd1;
    redirect_now(32'h0000_2000, 32'h0000_2000);
    check("t4_discard", 32'(dut.discard_q), exp_disc);
    wait_consumed("t4_new_path", 4, 40);

    // Back-to-back redirects while flushing: only the second path survives.
    mem_lat = 3;
    do_reset(1'b1);
    wait_pend("t5_outstanding", 3, 20);
    instr_ready = 1'b0;
    redirect_now(32'h0000_0200, 32'h0000_0300);
    check("t5_in_flush", {31'b0, dut.state_q == core_pkg::FLUSH}, 32'd1);
    redirect_now(32'h0000_0300, 32'h0000_0300);
    check("t5_addr", instr_addr, 32'h0000_0300);
    instr_ready = 1'b1;
    wait_consumed("t5_new_path", 4, 40);
    check("t5_first_req", acc_at(0), 32'h0000_0300);

    // Asynchronous reset with two requests in flight.
    mem_lat = 3;
    do_reset(1'b1);
    wait_pend("t6_outstanding", 2, 20);
    #1;
    rst = 1'b0;
    #1;
    check_reset_outputs("t6_async");
    repeat (2) step();
    acc_log.delete();
    expect_path(RESET_PC, 64);
    rst = 1'b1;
    wait_consumed("t6_restart", 4, 40);
    check("t6_first_req", acc_at(0), RESET_PC);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Parametrised instruction-fetch front end for the next-generation core, replacing the fixed "PC + always-read" fetch path.
- Issues sequential word fetches over a ready/valid instruction-memory port, tolerates multi-cycle memory latency with several requests outstanding, and buffers returned instructions in a DEPTH-entry queue.
- Hands (pc, instr) pairs to decode with a valid/ready handshake.
- Accepts redirects from branch/jump resolution, flushes the queue and discards stale in-flight responses.

Parameters:
- XLEN, 32, address and instruction width.
- DEPTH, 4, instruction queue entries; power of two, 2..16.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- instr_read  out  1  fetch request valid.
- instr_addr  out  XLEN  fetch request address, word aligned.
- instr_ready  in  1  memory accepts the request this cycle.
- instr_rvalid  in  1  response valid; responses return in request order.
- instr_out  in  XLEN  response instruction word.
- redirect_valid  in  1  control-flow change this cycle.
- redirect_pc  in  XLEN  new fetch address; bits [1:0] ignored and forced to 0.
- fetch_valid  out  1  queue head is valid.
- fetch_pc  out  XLEN  PC of the queue head.
- fetch_instr  out  XLEN  instruction at the queue head.
- fetch_ready  in  1  decode consumes the head.

Behaviour:
- Reset (rst=0, asynchronous):
  - instr_read=0, instr_addr=RESET_PC, fetch_valid=0, fetch_pc=0, fetch_instr=0.
  - Queue empty, outstanding=0, discard=0, state=IDLE.
- FSM:
  - IDLE: one cycle after reset release, then RUN.
  - RUN: normal issue.
  - FLUSH: entered on a redirect while outstanding>0. Returns to RUN in the cycle discard reaches 0.
- Request handshake:
  - A request is accepted when instr_read && instr_ready. instr_addr then advances by 4 (wraps modulo 2^XLEN).
  - instr_read and instr_addr must stay stable until accepted, unless a redirect occurs.
- Credit rule:
  - instr_read=1 only in RUN, and only when occupancy + outstanding < DEPTH. The queue can therefore never overflow.
  - outstanding counts accepted requests without a response yet. It is incremented on accept and decremented on rvalid, both possibly in the same cycle.
- Response handling:
  - In RUN, an instr_rvalid response is pushed at the queue tail as {pc, instr}. The pc is tracked by a response-PC register that advances by 4 per response.
  - Latency: a response arriving in cycle N is visible at fetch_pc/fetch_instr in cycle N+1 (registered queue). No bypass.
- Output handshake:
  - The head is popped on fetch_valid && fetch_ready.
  - A push and a pop in the same cycle are both performed, with no change in occupancy. This holds even when the queue is full.
  - fetch_valid=0 whenever the queue is empty.
- Redirect (highest priority, one-cycle pulse):
  - Queue cleared.
  - fetch_valid=0 in the next cycle.
  - instr_addr and response-PC := {redirect_pc[XLEN-1:2],2'b00}.
  - discard := outstanding minus any response arriving in that same cycle. That same-cycle response is dropped.
  - A request accepted in the redirect cycle is counted in discard; it was issued to the old path.
  - A pop in the redirect cycle is performed, then the queue is flushed.
  - If discard=0 after the update, stay in RUN.
- FLUSH:
  - instr_read=0.
  - Every instr_rvalid decrements discard and is dropped.
  - A second redirect during FLUSH updates the addresses. discard keeps its value, since no new requests were issued.
- Boundaries:
  - Full queue: no request issued.
  - Empty queue with outstanding=0 in RUN: request issued.
  - Reset mid-transfer: all state cleared. Responses to pre-reset requests are the memory model's responsibility and must not arrive.
- Pointers: log2(DEPTH) bits, plus a wrap bit to distinguish full from empty.

Decomposition:
- Shared package `core_pkg`: XLEN, RESET_PC default, fetch FSM state enum (IDLE, RUN, FLUSH), the ALIGN helper that clears bits [1:0].
- One sub-module, `fetch_queue`: a synchronous FIFO of {pc, instr} with push, pop, clear, full, empty and count. The parent holds the FSM, the counters and the PC registers.

Test Plan:
- Zero-wait memory (ready=1, rvalid one cycle after accept), fetch_ready=1 → fetch_pc sequence 0x0,0x4,0x8… one per cycle after the pipeline fills; instr matches memory.
- fetch_ready=0 for 10 cycles, DEPTH=4 → exactly 4 requests issued, then instr_read=0. On release, heads 0x0..0xC drain in order, then fetching resumes at 0x10.
- Memory latency 3 cycles, 3 requests outstanding, redirect to 0x1002 → 3 responses dropped, no fetch_valid for them, next request addr 0x1000, first fetch_pc 0x1000.
- Redirect in the same cycle as rvalid and a request accept → the response is dropped, discard = prior outstanding + 1 − 1, and no stale entry appears.
- Two redirects 1 cycle apart (0x200 then 0x300) during FLUSH → only 0x300-path instructions appear.
- Assert rst low mid-stream with 2 outstanding → outputs return to reset values immediately (asynchronously). After release, the first request addr = RESET_PC.
